// File: rtl/scazator_serial_4biti_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial subtractor.
interface scazator_serial_4biti_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] dif;
  logic             bout;
  logic             busy;
  logic             done;

  modport master (output start, i1, i2, input dif, bout, busy, done);
  modport slave  (input start, i1, i2, output dif, bout, busy, done);
endinterface

// File: rtl/scazator_serial_4biti.sv
// Bit-serial subtractor: dif = i1 - i2 (mod 2^WIDTH), bout = borrow, one bit per clock LSB first.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | shifting one bit per cycle through the full-subtractor cell
// DONE  | result just published, done pulse high
module scazator_serial_4biti #(
  parameter int WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  scazator_serial_4biti_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dif_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    d        = a[0] ^ b[0] ^ br;
    br_next  = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br);
    res_next = {d, res[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      dif_q  <= '0;
      bout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a      <= bus.i1;
            b      <= bus.i2;
            br     <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          res <= res_next;
          a   <= a >> 1;
          b   <= b >> 1;
          br  <= br_next;
          cnt <= cnt + 1'b1;
          // last bit: publish the full result together with the final borrow
          if (cnt == CW'(WIDTH - 1)) begin
            dif_q  <= res_next;
            bout_q <= br_next;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dif  = dif_q;
  assign bus.bout = bout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_scazator_serial_4biti.sv
// Self-checking bench for the bit-serial subtractor against an arithmetic reference model.
module tb_scazator_serial_4biti;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  scazator_serial_4biti_if #(.WIDTH(W)) bus ();

  scazator_serial_4biti #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an accepted start yields a result W edges later.
  int         pend = 0;
  int         op_a = 0;
  int         op_b = 0;
  logic [3:0] m_dif = '0;
  logic       m_bout = 1'b0;
  logic       m_done = 1'b0;
  logic       m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      pend = 0; m_dif = '0; m_bout = 1'b0; m_done = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_done = 1'b0;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          m_dif  = 4'((op_a - op_b + 16) % 16);
          m_bout = (op_a < op_b);
          m_done = 1'b1;
        end
      end else if (bus.start) begin
        op_a = int'(bus.i1);
        op_b = int'(bus.i2);
        pend = W;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", int'(bus.busy), int'(pend > 0));
      chk("done", int'(bus.done), int'(m_done));
      chk("dif",  int'(bus.dif),  int'(m_dif));
      chk("bout", int'(bus.bout), int'(m_bout));
      if (bus.busy && bus.done) chk("busy_done_excl", 1, 0);
      if (bus.done) chk("adder_identity", int'(4'(bus.i2 * 0 + op_b + bus.dif)), op_a);
    end
  end

  task automatic run_op(input int x, input int y, input int exp_d, input int exp_b);
    int n;
    bus.start = 1'b1; bus.i1 = 4'(x); bus.i2 = 4'(y);
    @(negedge clk);
    bus.start = 1'b0; bus.i1 = 4'($urandom); bus.i2 = 4'($urandom);
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk("done_timeout", 0, 1);
    chk("lit_dif",  int'(bus.dif),  exp_d);
    chk("lit_bout", int'(bus.bout), exp_b);
  endtask

  initial begin
    int busy_cycles;
    rst = 1'b1; bus.start = 1'b0; bus.i1 = '0; bus.i2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_dif", int'(bus.dif), 0);
    chk("reset_busy", int'(bus.busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // 12 - 14: also count busy cycles
    bus.start = 1'b1; bus.i1 = 4'd12; bus.i2 = 4'd14;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cycles = 0;
    while (bus.busy && busy_cycles < 20) begin
      busy_cycles++;
      @(negedge clk);
    end
    chk("busy_len", busy_cycles, 4);
    chk("first_done", int'(bus.done), 1);
    chk("first_dif", int'(bus.dif), 14);
    chk("first_bout", int'(bus.bout), 1);
    @(negedge clk);
    chk("done_one_cycle", int'(bus.done), 0);

    run_op(10, 9, 1, 0);
    repeat (3) @(negedge clk);
    chk("dif_hold", int'(bus.dif), 1);
    run_op(8, 6, 2, 0);
    run_op(0, 0, 0, 0);
    run_op(0, 15, 1, 1);
    run_op(15, 0, 15, 0);
    run_op(7, 7, 0, 0);

    // start held high, operands changing every cycle
    for (int k = 0; k < 40; k++) begin
      bus.start = 1'b1; bus.i1 = 4'($urandom); bus.i2 = 4'($urandom);
      @(negedge clk);
    end
    // random start pulses, many falling into RUN
    for (int k = 0; k < 200; k++) begin
      bus.start = ($urandom_range(0, 2) == 0);
      bus.i1 = 4'($urandom); bus.i2 = 4'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (8) @(negedge clk);

    // reset in the second RUN cycle aborts with no done
    run_op(3, 1, 2, 0);
    bus.start = 1'b1; bus.i1 = 4'd9; bus.i2 = 4'd4;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_dif",  int'(bus.dif), 0);
    chk("abort_bout", int'(bus.bout), 0);
    repeat (8) @(negedge clk);
    run_op(5, 3, 2, 0);

    // exhaustive operand pairs
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        run_op(x, y, (x - y + 16) % 16, int'(x < y));

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
